// File: rtl/dsram_store_ctrl_pkg.sv
// Shared definitions for the LSU store path: op codes, AXI response codes
// and the store controller's FSM state encoding.
package dsram_store_ctrl_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int LSU_OP_W = 4;

    // Load-side codes live in the same space so both paths decode one bus.
    localparam logic [LSU_OP_W-1:0] LSU_OP_NONE = 4'd0;
    localparam logic [LSU_OP_W-1:0] LSU_OP_LB   = 4'd1;
    localparam logic [LSU_OP_W-1:0] LSU_OP_LH   = 4'd2;
    localparam logic [LSU_OP_W-1:0] LSU_OP_LW   = 4'd3;
    localparam logic [LSU_OP_W-1:0] LSU_OP_LBU  = 4'd4;
    localparam logic [LSU_OP_W-1:0] LSU_OP_LHU  = 4'd5;
    localparam logic [LSU_OP_W-1:0] LSU_OP_SB   = 4'd6;
    localparam logic [LSU_OP_W-1:0] LSU_OP_SH   = 4'd7;
    localparam logic [LSU_OP_W-1:0] LSU_OP_SW   = 4'd8;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } store_state_t;

    function automatic logic [3:0] laneStrobe(input logic [3:0] baseMask, input logic [1:0] off);
        return baseMask << off;
    endfunction

endpackage

// File: rtl/dsram_store_ctrl_align.sv
// Combinational lane alignment for stores: replicates the store data across
// byte lanes, builds the byte strobes and flags misaligned accesses.
module store_lane_align
    import dsram_store_ctrl_pkg::*;
(
    input  logic [LSU_OP_W-1:0] i_lsuOp,
    input  logic [1:0]          i_off,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_wdata,
    output logic [3:0]          o_wstrb,
    output logic                o_misalign,
    output logic                o_isStore
);

    always_comb begin
        o_wdata    = 32'd0;
        o_wstrb    = 4'd0;
        o_misalign = 1'b0;
        o_isStore  = 1'b0;
        case (i_lsuOp)
            LSU_OP_SB: begin
                o_isStore = 1'b1;
                o_wdata   = {4{i_wdata[7:0]}};
                o_wstrb   = laneStrobe(4'b0001, i_off);
            end
            LSU_OP_SH: begin
                o_isStore  = 1'b1;
                o_wdata    = {2{i_wdata[15:0]}};
                o_wstrb    = laneStrobe(4'b0011, i_off);
                o_misalign = i_off[0];
            end
            LSU_OP_SW: begin
                o_isStore  = 1'b1;
                o_wdata    = i_wdata;
                o_wstrb    = 4'b1111;
                o_misalign = |i_off;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dsram_store_ctrl.sv
// Store controller: accepts an EXU store, issues one AXI4-Lite write to the
// data SRAM and returns a single-cycle done/err completion to the pipeline.
module dsram_store_ctrl
    import dsram_store_ctrl_pkg::*;
#(
    parameter int P_ADDR_W = ADDR_W,
    parameter int P_DATA_W = DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [LSU_OP_W-1:0] i_lsuOp,
    input  logic [P_ADDR_W-1:0] i_addr,
    input  logic [P_DATA_W-1:0] i_wdata,
    output logic [P_ADDR_W-1:0] o_awaddr,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [P_DATA_W-1:0] o_wdata,
    output logic [3:0]          o_wstrb,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic                i_bvalid,
    input  logic [1:0]          i_bresp,
    output logic                o_bready,
    output logic                o_done,
    output logic                o_err
);

    store_state_t        r_state;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_awDone;
    logic                r_wDone;
    logic                r_bready;
    logic                r_done;
    logic                r_err;
    logic [P_ADDR_W-1:0] r_awaddr;
    logic [P_DATA_W-1:0] r_wdata;
    logic [3:0]          r_wstrb;

    store_state_t        w_stateNext;
    logic                w_awvalidNext;
    logic                w_wvalidNext;
    logic                w_awDoneNext;
    logic                w_wDoneNext;
    logic                w_breadyNext;
    logic                w_doneNext;
    logic                w_errNext;
    logic [P_ADDR_W-1:0] w_awaddrNext;
    logic [P_DATA_W-1:0] w_wdataNext;
    logic [3:0]          w_wstrbNext;

    logic [31:0]         w_alignData;
    logic [3:0]          w_alignStrb;
    logic                w_misalign;
    logic                w_isStore;
    logic                w_awHs;
    logic                w_wHs;

    store_lane_align u_align (
        .i_lsuOp    (i_lsuOp),
        .i_off      (i_addr[1:0]),
        .i_wdata    (i_wdata[31:0]),
        .o_wdata    (w_alignData),
        .o_wstrb    (w_alignStrb),
        .o_misalign (w_misalign),
        .o_isStore  (w_isStore)
    );

    assign w_awHs = r_awvalid & i_awready;
    assign w_wHs  = r_wvalid & i_wready;

    // Next-state and next-output decode; AW and W retire independently and
    // the response phase starts once both sticky flags are (or become) set.
    always_comb begin
        w_stateNext   = r_state;
        w_awvalidNext = r_awvalid;
        w_wvalidNext  = r_wvalid;
        w_awDoneNext  = r_awDone;
        w_wDoneNext   = r_wDone;
        w_breadyNext  = r_bready;
        w_doneNext    = 1'b0;
        w_errNext     = 1'b0;
        w_awaddrNext  = r_awaddr;
        w_wdataNext   = r_wdata;
        w_wstrbNext   = r_wstrb;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    if (w_isStore && !w_misalign) begin
                        w_stateNext   = ST_SEND;
                        w_awvalidNext = 1'b1;
                        w_wvalidNext  = 1'b1;
                        w_awDoneNext  = 1'b0;
                        w_wDoneNext   = 1'b0;
                        w_awaddrNext  = {i_addr[P_ADDR_W-1:2], 2'b00};
                        w_wdataNext   = w_alignData;
                        w_wstrbNext   = w_alignStrb;
                    end else begin
                        // Misaligned stores and non-store ops complete without bus traffic.
                        w_doneNext = 1'b1;
                        w_errNext  = w_isStore;
                    end
                end
            end
            ST_SEND: begin
                if (w_awHs) begin
                    w_awvalidNext = 1'b0;
                    w_awDoneNext  = 1'b1;
                end
                if (w_wHs) begin
                    w_wvalidNext = 1'b0;
                    w_wDoneNext  = 1'b1;
                end
                if ((r_awDone || w_awHs) && (r_wDone || w_wHs)) begin
                    w_stateNext  = ST_RESP;
                    w_breadyNext = 1'b1;
                end
            end
            ST_RESP: begin
                if (i_bvalid) begin
                    w_stateNext  = ST_IDLE;
                    w_breadyNext = 1'b0;
                    w_doneNext   = 1'b1;
                    w_errNext    = (i_bresp != AXI_RESP_OKAY);
                end
            end
            default: begin
                w_stateNext   = ST_IDLE;
                w_awvalidNext = 1'b0;
                w_wvalidNext  = 1'b0;
                w_breadyNext  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_awDone  <= 1'b0;
            r_wDone   <= 1'b0;
            r_bready  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= 4'd0;
        end else begin
            r_state   <= w_stateNext;
            r_awvalid <= w_awvalidNext;
            r_wvalid  <= w_wvalidNext;
            r_awDone  <= w_awDoneNext;
            r_wDone   <= w_wDoneNext;
            r_bready  <= w_breadyNext;
            r_done    <= w_doneNext;
            r_err     <= w_errNext;
            r_awaddr  <= w_awaddrNext;
            r_wdata   <= w_wdataNext;
            r_wstrb   <= w_wstrbNext;
        end
    end

    assign o_ready   = (r_state == ST_IDLE);
    assign o_awaddr  = r_awaddr;
    assign o_awvalid = r_awvalid;
    assign o_wdata   = r_wdata;
    assign o_wstrb   = r_wstrb;
    assign o_wvalid  = r_wvalid;
    assign o_bready  = r_bready;
    assign o_done    = r_done;
    assign o_err     = r_err;

endmodule
